// File: rtl/rmt_ctrl_pkg.sv
// RMT control-channel definitions shared by the packet generator and
// the stage-side decoder: header layout, resource IDs and FSM states.
package rmt_ctrl_pkg;

    localparam logic [15:0] CTRL_MAGIC = 16'hF2F1;

    localparam logic [3:0] RES_KEY_OFF = 4'd0;
    localparam logic [3:0] RES_CAM     = 4'd1;
    localparam logic [3:0] RES_ACT     = 4'd2;

    localparam int HDR_MAGIC_LSB = 0;
    localparam int HDR_MAGIC_W   = 16;
    localparam int HDR_STAGE_LSB = 16;
    localparam int HDR_STAGE_W   = 5;
    localparam int HDR_RES_LSB   = 21;
    localparam int HDR_RES_W     = 4;
    localparam int HDR_ADDR_LSB  = 25;
    localparam int HDR_ADDR_W    = 8;
    localparam int HDR_SEQ_LSB   = 33;
    localparam int HDR_SEQ_W     = 8;
    localparam int HDR_NB_LSB    = 41;
    localparam int HDR_NB_W      = 2;
    localparam int HDR_W         = 43;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_PLD
    } gen_state_e;

    // First member lands in the MSBs, so magic ends up at [15:0].
    typedef struct packed {
        logic [HDR_NB_W-1:0]    nbeats;
        logic [HDR_SEQ_W-1:0]   seq;
        logic [HDR_ADDR_W-1:0]  addr;
        logic [HDR_RES_W-1:0]   res;
        logic [HDR_STAGE_W-1:0] stage;
        logic [HDR_MAGIC_W-1:0] magic;
    } ctrl_hdr_t;

    function automatic ctrl_hdr_t hdr_pack(
        input logic [15:0] magic,
        input logic [4:0]  stage,
        input logic [3:0]  res,
        input logic [7:0]  addr,
        input logic [7:0]  seq,
        input logic [1:0]  nbeats
    );
        ctrl_hdr_t h;
        h.magic  = magic;
        h.stage  = stage;
        h.res    = res;
        h.addr   = addr;
        h.seq    = seq;
        h.nbeats = nbeats;
        return h;
    endfunction

endpackage

// File: rtl/ctrl_pkt_gen.sv
// Control-packet transmitter: one write request becomes a header beat
// plus up to MAX_PLD_BEATS payload beats on the AXI-Stream control bus.
module ctrl_pkt_gen
    import rmt_ctrl_pkg::*;
#(
    parameter int          C_S_AXIS_DATA_WIDTH  = 256,
    parameter int          C_S_AXIS_TUSER_WIDTH = 128,
    parameter int          MAX_PLD_BEATS        = 3,
    parameter logic [15:0] CTRL_MAGIC           = rmt_ctrl_pkg::CTRL_MAGIC
) (
    input  logic                                     axis_clk,
    input  logic                                     areset,
    input  logic                                     req_valid,
    output logic                                     req_ready,
    input  logic [4:0]                               req_stage_id,
    input  logic [3:0]                               req_resource_id,
    input  logic [7:0]                               req_addr,
    input  logic [1:0]                               req_nbeats,
    input  logic [5:0]                               req_last_bytes,
    input  logic [MAX_PLD_BEATS*C_S_AXIS_DATA_WIDTH-1:0] req_data,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]           c_m_axis_tdata,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]          c_m_axis_tuser,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]         c_m_axis_tkeep,
    output logic                                     c_m_axis_tvalid,
    input  logic                                     c_m_axis_tready,
    output logic                                     c_m_axis_tlast,
    output logic                                     pkt_done,
    output logic                                     req_clamped
);

    localparam int DW = C_S_AXIS_DATA_WIDTH;
    localparam int TW = C_S_AXIS_TUSER_WIDTH;
    localparam int KW = DW / 8;
    localparam int PW = MAX_PLD_BEATS * DW;

    function automatic int eff_bytes(input logic [5:0] lb);
        if (lb == 6'd0 || int'(lb) > KW) begin
            return KW;
        end
        return int'(lb);
    endfunction

    function automatic logic [KW-1:0] keep_for(input logic [5:0] lb);
        logic [KW-1:0] k;
        int            n;
        n = eff_bytes(lb);
        for (int i = 0; i < KW; i++) begin
            k[i] = (i < n);
        end
        return k;
    endfunction

    gen_state_e      state_q, state_d;
    logic [DW-1:0]   tdata_q, tdata_d;
    logic [TW-1:0]   tuser_q, tuser_d;
    logic [KW-1:0]   tkeep_q, tkeep_d;
    logic            tvalid_q, tvalid_d;
    logic            tlast_q, tlast_d;
    logic [7:0]      seq_q, seq_d;
    logic [1:0]      beat_q, beat_d;
    logic [1:0]      nbeats_q, nbeats_d;
    logic [5:0]      lb_q, lb_d;
    logic [PW-1:0]   pld_q, pld_d;

    logic            hs;
    logic            clamp;
    logic [1:0]      nb_eff;
    logic [1:0]      beat_sel;
    logic [DW-1:0]   pld_beat;
    logic            pld_last;
    logic [15:0]     byte_len;
    ctrl_hdr_t       hdr;

    assign hs          = tvalid_q & c_m_axis_tready;
    assign req_ready   = (state_q == ST_IDLE);
    assign pkt_done    = hs & tlast_q;
    assign clamp       = int'(req_nbeats) > MAX_PLD_BEATS;
    assign req_clamped = req_valid & req_ready & clamp;
    assign nb_eff      = clamp ? 2'(MAX_PLD_BEATS) : req_nbeats;

    assign byte_len = (nb_eff == 2'd0) ? 16'(KW)
                    : 16'(KW * int'(nb_eff) + eff_bytes(req_last_bytes));

    assign hdr = hdr_pack(CTRL_MAGIC, req_stage_id, req_resource_id,
                          req_addr, seq_q, nb_eff);

    // HDR always hands over to payload beat 0; PLD moves to the next beat.
    assign beat_sel = (state_q == ST_HDR) ? 2'd0 : beat_q + 2'd1;
    assign pld_beat = pld_q[int'(beat_sel)*DW +: DW];
    assign pld_last = (beat_sel == nbeats_q - 2'd1);

    always_comb begin
        state_d  = state_q;
        tdata_d  = tdata_q;
        tuser_d  = tuser_q;
        tkeep_d  = tkeep_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        seq_d    = seq_q;
        beat_d   = beat_q;
        nbeats_d = nbeats_q;
        lb_d     = lb_q;
        pld_d    = pld_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    tdata_d             = '0;
                    tdata_d[HDR_W-1:0]  = hdr;
                    tuser_d             = '0;
                    tuser_d[15:0]       = byte_len;
                    tkeep_d             = '1;
                    tvalid_d            = 1'b1;
                    tlast_d             = (nb_eff == 2'd0);
                    nbeats_d            = nb_eff;
                    lb_d                = req_last_bytes;
                    pld_d               = req_data;
                    beat_d              = 2'd0;
                    state_d             = ST_HDR;
                end
            end
            ST_HDR, ST_PLD: begin
                if (hs) begin
                    if (tlast_q) begin
                        tdata_d  = '0;
                        tuser_d  = '0;
                        tkeep_d  = '0;
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        state_d  = ST_IDLE;
                    end else begin
                        tdata_d  = pld_beat;
                        tuser_d  = '0;
                        tkeep_d  = pld_last ? keep_for(lb_q) : '1;
                        tlast_d  = pld_last;
                        beat_d   = beat_sel;
                        state_d  = ST_PLD;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (hs && tlast_q) begin
            seq_d = seq_q + 8'd1;
        end
    end

    always_ff @(posedge axis_clk or posedge areset) begin
        if (areset) begin
            state_q  <= ST_IDLE;
            tdata_q  <= '0;
            tuser_q  <= '0;
            tkeep_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            seq_q    <= 8'd0;
            beat_q   <= 2'd0;
            nbeats_q <= 2'd0;
            lb_q     <= 6'd0;
            pld_q    <= '0;
        end else begin
            state_q  <= state_d;
            tdata_q  <= tdata_d;
            tuser_q  <= tuser_d;
            tkeep_q  <= tkeep_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            seq_q    <= seq_d;
            beat_q   <= beat_d;
            nbeats_q <= nbeats_d;
            lb_q     <= lb_d;
            pld_q    <= pld_d;
        end
    end

    assign c_m_axis_tdata  = tdata_q;
    assign c_m_axis_tuser  = tuser_q;
    assign c_m_axis_tkeep  = tkeep_q;
    assign c_m_axis_tvalid = tvalid_q;
    assign c_m_axis_tlast  = tlast_q;

endmodule

// File: tb/tb_ctrl_pkt_gen.sv
// Scoreboard bench for ctrl_pkt_gen: expected beats are queued when a
// request is driven and compared as the stream hands them over.
module tb_ctrl_pkt_gen;

    typedef struct {
        logic [255:0] data;
        logic [31:0]  keep;
        logic         last;
        logic [127:0] user;
        logic         hdr;
    } beat_t;

    logic         clk = 1'b0;
    logic         areset;
    logic         req_valid;
    logic         req_ready;
    logic [4:0]   req_stage_id;
    logic [3:0]   req_resource_id;
    logic [7:0]   req_addr;
    logic [1:0]   req_nbeats;
    logic [5:0]   req_last_bytes;
    logic [767:0] req_data;
    logic [255:0] tdata;
    logic [127:0] tuser;
    logic [31:0]  tkeep;
    logic         tvalid;
    logic         tready;
    logic         tlast;
    logic         pkt_done;
    logic         req_clamped;

    int    total  = 0;
    int    passed = 0;
    int    cyc    = 0;
    int    last_cyc = 0;
    bit    gap_mode  = 1'b0;
    bit    gap_armed = 1'b0;
    bit    held_v    = 1'b0;
    beat_t held;
    beat_t e;
    beat_t sb[$];
    logic [7:0] exp_seq = 8'd0;

    ctrl_pkt_gen dut (
        .axis_clk        (clk),
        .areset          (areset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_stage_id    (req_stage_id),
        .req_resource_id (req_resource_id),
        .req_addr        (req_addr),
        .req_nbeats      (req_nbeats),
        .req_last_bytes  (req_last_bytes),
        .req_data        (req_data),
        .c_m_axis_tdata  (tdata),
        .c_m_axis_tuser  (tuser),
        .c_m_axis_tkeep  (tkeep),
        .c_m_axis_tvalid (tvalid),
        .c_m_axis_tready (tready),
        .c_m_axis_tlast  (tlast),
        .pkt_done        (pkt_done),
        .req_clamped     (req_clamped)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] keepf(input int eff);
        if (eff >= 32) return 32'hFFFF_FFFF;
        return (32'h1 << eff) - 32'h1;
    endfunction

    function automatic logic [767:0] rnd_data();
        logic [767:0] d;
        for (int i = 0; i < 24; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic send(input logic [4:0] st, input logic [3:0] rs,
                        input logic [7:0] ad, input logic [1:0] nb,
                        input logic [5:0] lb, input logic [767:0] d);
        beat_t b;
        int    eff;
        int    ok;
        eff = (lb == 0 || lb > 32) ? 32 : int'(lb);
        b.data        = '0;
        b.data[15:0]  = 16'hF2F1;
        b.data[20:16] = st;
        b.data[24:21] = rs;
        b.data[32:25] = ad;
        b.data[40:33] = exp_seq;
        b.data[42:41] = nb;
        b.keep        = 32'hFFFF_FFFF;
        b.last        = (nb == 0);
        b.user        = '0;
        b.user[15:0]  = (nb == 0) ? 16'd32 : 16'(32 * int'(nb) + eff);
        b.hdr         = 1'b1;
        sb.push_back(b);
        for (int k = 0; k < int'(nb); k++) begin
            b.data = d[k*256 +: 256];
            b.keep = (k == int'(nb) - 1) ? keepf(eff) : 32'hFFFF_FFFF;
            b.last = (k == int'(nb) - 1);
            b.user = '0;
            b.hdr  = 1'b0;
            sb.push_back(b);
        end
        exp_seq = exp_seq + 8'd1;
        req_stage_id    = st;
        req_resource_id = rs;
        req_addr        = ad;
        req_nbeats      = nb;
        req_last_bytes  = lb;
        req_data        = d;
        req_valid       = 1'b1;
        ok = 0;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        if (ok == 0) chk("req_accept_timeout", 256'(ok), 256'd1);
    endtask

    task automatic wait_idle();
        int left;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (sb.size() == 0 && !tvalid) break;
        end
        left = sb.size();
        chk("drain", 256'(left), 256'd0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (areset) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                chk("hold_tvalid", 256'(tvalid), 256'd1);
                chk("hold_tdata", tdata, held.data);
                chk("hold_tkeep", 256'(tkeep), 256'(held.keep));
                chk("hold_tlast", 256'(tlast), 256'(held.last));
            end
            if (tvalid) begin
                chk("req_ready_busy", 256'(req_ready), 256'd0);
                if (tready) begin
                    held_v = 1'b0;
                    if (sb.size() == 0) begin
                        chk("unexpected_beat", 256'(tvalid), 256'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("tdata", tdata, e.data);
                        chk("tkeep", 256'(tkeep), 256'(e.keep));
                        chk("tlast", 256'(tlast), 256'(e.last));
                        chk("tuser", 256'(tuser), 256'(e.user));
                        chk("pkt_done", 256'(pkt_done), 256'(e.last));
                        if (e.hdr && gap_mode && gap_armed)
                            chk("hdr_gap", 256'(cyc - last_cyc), 256'd2);
                        if (e.last) begin
                            gap_armed = 1'b1;
                            last_cyc  = cyc;
                        end
                    end
                end else begin
                    held_v    = 1'b1;
                    held.data = tdata;
                    held.keep = tkeep;
                    held.last = tlast;
                end
            end else begin
                held_v = 1'b0;
                chk("pkt_done_idle", 256'(pkt_done), 256'd0);
            end
        end
    end

    initial begin
        logic [5:0] lbtab [4];
        lbtab[0] = 6'd4;
        lbtab[1] = 6'd0;
        lbtab[2] = 6'd40;
        lbtab[3] = 6'd32;
        areset          = 1'b1;
        tready          = 1'b1;
        req_valid       = 1'b0;
        req_stage_id    = '0;
        req_resource_id = '0;
        req_addr        = '0;
        req_nbeats      = '0;
        req_last_bytes  = '0;
        req_data        = '0;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_tvalid", 256'(tvalid), 256'd0);
        chk("rst_req_ready", 256'(req_ready), 256'd1);
        chk("rst_tdata", tdata, 256'd0);
        chk("rst_tkeep", 256'(tkeep), 256'd0);
        chk("rst_tlast", 256'(tlast), 256'd0);
        chk("rst_pkt_done", 256'(pkt_done), 256'd0);
        chk("rst_clamped", 256'(req_clamped), 256'd0);
        @(posedge clk);
        #1 areset = 1'b0;

        // first request carries seq 0
        send(5'd1, 4'd0, 8'h00, 2'd1, 6'd8, rnd_data());
        wait_idle();

        // header-only packet
        send(5'd2, 4'd1, 8'h05, 2'd0, 6'd0, rnd_data());
        wait_idle();

        // full packet, 4-byte tail
        send(5'd3, 4'd2, 8'h10, 2'd3, 6'd4, rnd_data());
        wait_idle();

        // backpressure on header and on payload beat 2
        tready = 1'b0;
        send(5'd4, 4'd1, 8'h22, 2'd3, 6'd20, rnd_data());
        repeat (5) @(posedge clk);
        #1 tready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 tready = 1'b0;
        repeat (5) @(posedge clk);
        #1 tready = 1'b1;
        wait_idle();

        areset = 1'b1;
        @(posedge clk);
        #1 areset = 1'b0;
        exp_seq = 8'd0;

        // back-to-back run through a seq wrap
        gap_mode  = 1'b1;
        gap_armed = 1'b0;
        for (int i = 0; i < 257; i++) begin
            send(5'(i % 32), 4'(i % 4), 8'(i), 2'(i % 4),
                 lbtab[i % 4], rnd_data());
        end
        wait_idle();
        gap_mode = 1'b0;

        // reset mid-packet
        tready = 1'b0;
        send(5'd7, 4'd2, 8'h33, 2'd3, 6'd0, rnd_data());
        #1 tready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 tready = 1'b0;
        areset = 1'b1;
        #1;
        chk("mid_rst_tvalid", 256'(tvalid), 256'd0);
        chk("mid_rst_req_ready", 256'(req_ready), 256'd1);
        sb.delete();
        exp_seq = 8'd0;
        @(posedge clk);
        #1 areset = 1'b0;
        tready = 1'b1;
        send(5'd9, 4'd3, 8'h44, 2'd2, 6'd17, rnd_data());
        wait_idle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
